// File: rtl/draw_wall_if.sv
// rtl/draw_wall_if.sv - VGA pixel-stream bundle (counters, sync, blank, colour)
interface draw_wall_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport slave (
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_wall.sv
// rtl/draw_wall.sv - 3-stage VGA draw stage overlaying the wall ROM bitmap
module draw_wall #(
  parameter int          WALL_W      = 64,
  parameter int          WALL_H      = 128,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  localparam int         AW_X        = $clog2(WALL_W),
  localparam int         AW_Y        = $clog2(WALL_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  draw_wall_if.slave           vga_in,
  draw_wall_if.master          vga_out,
  input  logic [10:0]          wall_x,
  input  logic [10:0]          wall_y,
  input  logic                 wall_en,
  output logic [AW_Y+AW_X-1:0] rom_address,
  input  logic [11:0]          rom_rgb
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    logic        hit;
  } stage_t;

  logic                 vblnk_prev_q, vblnk_prev_d;
  logic [10:0]          x_act_q, x_act_d;
  logic [10:0]          y_act_q, y_act_d;
  logic                 en_act_q, en_act_d;
  logic [AW_Y+AW_X-1:0] rom_address_q, rom_address_d;
  stage_t               d1_q, d1_d;
  stage_t               d2_q, d2_d;
  logic [25:0]          out_tim_q, out_tim_d;
  logic [11:0]          out_rgb_q, out_rgb_d;
  logic [11:0]          dx, dy;
  logic                 hit;

  // Shadow the requested position only at a vblnk rising edge so a frame never tears
  always_comb begin
    vblnk_prev_d = vga_in.vblnk;
    x_act_d      = x_act_q;
    y_act_d      = y_act_q;
    en_act_d     = en_act_q;
    if (vga_in.vblnk && !vblnk_prev_q) begin
      x_act_d  = wall_x;
      y_act_d  = wall_y;
      en_act_d = wall_en;
    end
  end

  // Stage 1: 12-bit offsets so left/above-wall pixels wrap large and miss
  always_comb begin
    dx            = {1'b0, vga_in.hcount} - {1'b0, x_act_q};
    dy            = {1'b0, vga_in.vcount} - {1'b0, y_act_q};
    hit           = en_act_q & (dx < 12'(WALL_W)) & (dy < 12'(WALL_H));
    rom_address_d = {dy[AW_Y-1:0], dx[AW_X-1:0]};
    d1_d.hcount   = vga_in.hcount;
    d1_d.vcount   = vga_in.vcount;
    d1_d.hsync    = vga_in.hsync;
    d1_d.vsync    = vga_in.vsync;
    d1_d.hblnk    = vga_in.hblnk;
    d1_d.vblnk    = vga_in.vblnk;
    d1_d.rgb      = vga_in.rgb;
    d1_d.hit      = hit;
  end

  // Stages 2 and 3: wait for the ROM pixel, then composite (blanking wins, then opaque wall)
  always_comb begin
    d2_d      = d1_q;
    out_tim_d = {d2_q.hcount, d2_q.vcount, d2_q.hsync, d2_q.vsync, d2_q.hblnk, d2_q.vblnk};
    out_rgb_d = d2_q.rgb;
    if (d2_q.hblnk || d2_q.vblnk) begin
      out_rgb_d = 12'h000;
    end else if (d2_q.hit && (rom_rgb != TRANSPARENT)) begin
      out_rgb_d = rom_rgb;
    end
  end

  // State register for shadows, pipeline stages and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev_q  <= 1'b0;
      x_act_q       <= '0;
      y_act_q       <= '0;
      en_act_q      <= 1'b0;
      rom_address_q <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      out_tim_q     <= '0;
      out_rgb_q     <= '0;
    end else begin
      vblnk_prev_q  <= vblnk_prev_d;
      x_act_q       <= x_act_d;
      y_act_q       <= y_act_d;
      en_act_q      <= en_act_d;
      rom_address_q <= rom_address_d;
      d1_q          <= d1_d;
      d2_q          <= d2_d;
      out_tim_q     <= out_tim_d;
      out_rgb_q     <= out_rgb_d;
    end
  end

  assign rom_address    = rom_address_q;
  assign vga_out.hcount = out_tim_q[25:15];
  assign vga_out.vcount = out_tim_q[14:4];
  assign vga_out.hsync  = out_tim_q[3];
  assign vga_out.vsync  = out_tim_q[2];
  assign vga_out.hblnk  = out_tim_q[1];
  assign vga_out.vblnk  = out_tim_q[0];
  assign vga_out.rgb    = out_rgb_q;

endmodule
